// File: rtl/lfsr_rng_if.sv
// Sample/handshake bundle between the LFSR random source and its consumer.
// The master side is the generator; the slave side is the game logic.
interface lfsr_rng_if #(
  parameter int unsigned WIDTH = 13
);
  logic             enable;
  logic             seed_load;
  logic [WIDTH-1:0] seed_in;
  logic [WIDTH-1:0] rnd;
  logic             rnd_valid;
  logic             rnd_ready;

  modport master (
    input  enable,
    input  seed_load,
    input  seed_in,
    input  rnd_ready,
    output rnd,
    output rnd_valid
  );

  modport slave (
    output enable,
    output seed_load,
    output seed_in,
    output rnd_ready,
    input  rnd,
    input  rnd_valid
  );
endinterface

// File: rtl/lfsr_rng.sv
// Fibonacci LFSR random source: publishes one sample every SHIFTS enabled shifts
// through a valid/ready register, stalling at the terminal count instead of dropping.
module lfsr_rng #(
  parameter int unsigned      WIDTH  = 13,
  parameter logic [WIDTH-1:0] TAPS   = 13'h100D,
  parameter logic [WIDTH-1:0] SEED   = 13'h000F,
  parameter int unsigned      SHIFTS = WIDTH
) (
  input  logic         clock,
  input  logic         reset_n,
  lfsr_rng_if.master   bus
);

  localparam logic [7:0] LAST = 8'(SHIFTS - 1);

  logic [WIDTH-1:0] state;
  logic [7:0]       count;
  logic [WIDTH-1:0] rnd;
  logic             rnd_valid;

  logic [WIDTH-1:0] shifted;
  logic             terminal;
  logic             stall;
  logic             shift;
  logic             publish;
  logic             consume;

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], ^(s & TAPS)};
  endfunction

  // A zero seed would lock the register up, so it is replaced by SEED.
  function automatic logic [WIDTH-1:0] seed_fix(input logic [WIDTH-1:0] s);
    return (s == '0) ? SEED : s;
  endfunction

  always_comb begin
    shifted  = lfsr_step(state);
    terminal = (count == LAST);
    stall    = terminal && rnd_valid && !bus.rnd_ready;
    shift    = bus.enable && !bus.seed_load && !stall;
    publish  = shift && terminal;
    consume  = rnd_valid && bus.rnd_ready;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= SEED;
      count     <= '0;
      rnd       <= '0;
      rnd_valid <= 1'b0;
    end else if (bus.seed_load) begin
      // Seed load discards a pending sample but leaves rnd untouched.
      state     <= seed_fix(bus.seed_in);
      count     <= '0;
      rnd_valid <= 1'b0;
    end else begin
      if (shift) begin
        state <= shifted;
        count <= terminal ? 8'd0 : 8'(count + 8'd1);
      end
      // Publishing wins over consuming, so back-to-back samples have no bubble.
      if (publish) begin
        rnd       <= shifted;
        rnd_valid <= 1'b1;
      end else if (consume) begin
        rnd_valid <= 1'b0;
      end
    end
  end

  assign bus.rnd       = rnd;
  assign bus.rnd_valid = rnd_valid;

endmodule

// File: tb/tb_lfsr_rng.sv
// Self-checking bench for lfsr_rng: default-sequence table, stall, seed load,
// reset mid-stall, and a randomized enable pattern with SHIFTS=1.
module tb_lfsr_rng;

  localparam logic [12:0] TAPS = 13'h100D;
  localparam logic [12:0] SEED = 13'h000F;

  typedef struct {
    int          shifts;
    logic [12:0] state;
  } vec_t;

  logic clock;
  logic reset_n;
  int   checks;
  int   failures;

  lfsr_rng_if #(.WIDTH(13)) bus0 ();
  lfsr_rng_if #(.WIDTH(13)) bus1 ();

  lfsr_rng dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus0)
  );

  lfsr_rng #(.SHIFTS(1)) dut1 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: count the tapped ones; an odd count feeds a 1 into bit 0.
  function automatic logic [12:0] ref_next(input logic [12:0] s);
    int ones;
    ones = $countones(s & TAPS);
    return 13'((s << 1) | 13'(ones % 2));
  endfunction

  function automatic logic [12:0] ref_after(input logic [12:0] s, input int n);
    logic [12:0] r;
    r = s;
    for (int i = 0; i < n; i++) r = ref_next(r);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  vec_t        vecs[13];
  logic [12:0] held;
  logic [12:0] mstate;
  int          nsamples;
  int          nenabled;
  logic        en;

  initial begin
    checks   = 0;
    failures = 0;
    vecs[0]  = '{1,  13'h001F};
    vecs[1]  = '{2,  13'h003F};
    vecs[2]  = '{3,  13'h007F};
    vecs[3]  = '{4,  13'h00FF};
    vecs[4]  = '{5,  13'h01FF};
    vecs[5]  = '{6,  13'h03FF};
    vecs[6]  = '{7,  13'h07FF};
    vecs[7]  = '{8,  13'h0FFF};
    vecs[8]  = '{9,  13'h1FFF};
    vecs[9]  = '{10, 13'h1FFE};
    vecs[10] = '{11, 13'h1FFD};
    vecs[11] = '{12, 13'h1FFA};
    vecs[12] = '{13, 13'h1FF4};

    reset_n        = 1'b0;
    bus0.enable    = 1'b0;
    bus0.seed_load = 1'b0;
    bus0.seed_in   = '0;
    bus0.rnd_ready = 1'b0;
    bus1.enable    = 1'b0;
    bus1.seed_load = 1'b0;
    bus1.seed_in   = '0;
    bus1.rnd_ready = 1'b1;

    #22;
    chk("reset_rnd",   32'(bus0.rnd), 32'h0);
    chk("reset_valid", 32'(bus0.rnd_valid), 32'h0);
    chk("reset_state", 32'(dut.state), 32'(SEED));
    chk("reset_count", 32'(dut.count), 32'h0);
    reset_n     = 1'b1;
    bus0.enable = 1'b1;

    // Default sequence from the table.
    for (int i = 0; i < 13; i++) begin
      step();
      chk($sformatf("seq_state_%0d", vecs[i].shifts), 32'(dut.state), 32'(vecs[i].state));
      chk($sformatf("seq_model_%0d", vecs[i].shifts), 32'(dut.state), 32'(ref_after(SEED, vecs[i].shifts)));
      if (i < 12) chk($sformatf("seq_novalid_%0d", vecs[i].shifts), 32'(bus0.rnd_valid), 32'h0);
    end
    chk("first_rnd",   32'(bus0.rnd), 32'h1FF4);
    chk("first_valid", 32'(bus0.rnd_valid), 32'h1);

    // Stall: intermediate shifts continue, then the generator parks at terminal count.
    for (int i = 0; i < 40; i++) begin
      step();
      chk("stall_rnd",   32'(bus0.rnd), 32'h1FF4);
      chk("stall_valid", 32'(bus0.rnd_valid), 32'h1);
    end
    chk("stall_state", 32'(dut.state), 32'(ref_after(13'h1FF4, 12)));
    chk("stall_count", 32'(dut.count), 32'd12);

    bus0.rnd_ready = 1'b1;
    step();
    bus0.rnd_ready = 1'b0;
    held = ref_after(13'h1FF4, 13);
    chk("b2b_rnd",   32'(bus0.rnd), 32'(held));
    chk("b2b_valid", 32'(bus0.rnd_valid), 32'h1);
    chk("b2b_count", 32'(dut.count), 32'h0);

    // Seed load with a sample pending.
    bus0.seed_in   = 13'h0001;
    bus0.seed_load = 1'b1;
    step();
    bus0.seed_load = 1'b0;
    chk("seed_valid", 32'(bus0.rnd_valid), 32'h0);
    chk("seed_state", 32'(dut.state), 32'h0001);
    chk("seed_count", 32'(dut.count), 32'h0);
    chk("seed_rnd",   32'(bus0.rnd), 32'(held));
    step();
    chk("seed_shift1", 32'(dut.state), 32'h0003);
    step();
    chk("seed_shift2", 32'(dut.state), 32'h0007);

    // Zero seed is replaced by SEED.
    bus0.seed_in   = 13'h0000;
    bus0.seed_load = 1'b1;
    step();
    bus0.seed_load = 1'b0;
    chk("zseed_state", 32'(dut.state), 32'(SEED));
    chk("zseed_count", 32'(dut.count), 32'h0);

    // Run into a stall, then assert reset between clock edges.
    for (int i = 0; i < 30; i++) step();
    chk("pre_rst_valid", 32'(bus0.rnd_valid), 32'h1);
    chk("pre_rst_rnd",   32'(bus0.rnd), 32'(ref_after(SEED, 13)));
    chk("pre_rst_count", 32'(dut.count), 32'd12);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_rnd",   32'(bus0.rnd), 32'h0);
    chk("async_rst_valid", 32'(bus0.rnd_valid), 32'h0);
    chk("async_rst_state", 32'(dut.state), 32'(SEED));
    bus0.enable = 1'b0;
    step();
    reset_n = 1'b1;
    step();

    // SHIFTS=1, rnd_ready=1, random enable: a sample per enabled edge only.
    mstate   = SEED;
    nsamples = 0;
    nenabled = 0;
    for (int i = 0; i < 300; i++) begin
      en = 1'($urandom_range(0, 1));
      bus1.enable = en;
      step();
      if (bus1.rnd_valid) nsamples++;
      if (en) begin
        nenabled++;
        mstate = ref_next(mstate);
        chk("gap_valid_on",  32'(bus1.rnd_valid), 32'h1);
        chk("gap_rnd",       32'(bus1.rnd), 32'(mstate));
      end else begin
        chk("gap_valid_off", 32'(bus1.rnd_valid), 32'h0);
      end
    end
    chk("gap_sample_count", 32'(nsamples), 32'(nenabled));
    bus1.enable = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
